// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: op encodings, reset level,
// FSM state encodings and divide-by-zero constants.
package ex_stage_pkg;

    localparam int ALU_Len    = 5;
    localparam int Branch_Len = 3;

    localparam logic ResetEnable = 1'b1;

    // ALU operation encodings
    localparam logic [ALU_Len-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_Len-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_Len-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_Len-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_Len-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_Len-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_Len-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_Len-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_Len-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_Len-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_Len-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALU_Len-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALU_Len-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALU_Len-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALU_Len-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALU_Len-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALU_Len-1:0] ALU_REM    = 5'd16;
    localparam logic [ALU_Len-1:0] ALU_REMU   = 5'd17;

    // Branch condition encodings; BR_NONE marks a non-branch instruction
    localparam logic [Branch_Len-1:0] BR_NONE = 3'd0;
    localparam logic [Branch_Len-1:0] BR_BEQ  = 3'd1;
    localparam logic [Branch_Len-1:0] BR_BNE  = 3'd2;
    localparam logic [Branch_Len-1:0] BR_BLT  = 3'd3;
    localparam logic [Branch_Len-1:0] BR_BGE  = 3'd4;
    localparam logic [Branch_Len-1:0] BR_BLTU = 3'd5;
    localparam logic [Branch_Len-1:0] BR_BGEU = 3'd6;

    // Multi-cycle unit FSM states
    typedef logic [1:0] ex_state_t;
    localparam ex_state_t EX_IDLE = 2'd0;
    localparam ex_state_t EX_BUSY = 2'd1;
    localparam ex_state_t EX_DONE = 2'd2;

    // Divide-by-zero: quotient is all ones, remainder is the dividend
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_div_op(input logic [ALU_Len-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [ALU_Len-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit. Restoring radix-2 divider and shift-add
// multiplier sharing one IDLE/BUSY/DONE FSM and step counter. Multiplies
// are only sent here when MUL_FAST_EN is undefined. The FSM state is
// exported on 'state' for observation.
module ex_muldiv
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [ALU_Len-1:0] op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    output logic               busy,
    output logic               done,
    output ex_state_t          state,
    output logic [XLEN-1:0]    result
);

    localparam int CW = $clog2(DIV_STEPS);

    ex_state_t          state_q;
    logic [CW-1:0]      count_q;
    logic [XLEN-1:0]    rem_q;    // divide: partial remainder; multiply: product high half
    logic [XLEN-1:0]    quo_q;    // divide: dividend/quotient; multiply: multiplier/product low half
    logic [XLEN-1:0]    dvs_q;    // divisor or multiplicand magnitude
    logic               neg_q;    // negate quotient / product
    logic               rneg_q;   // negate remainder
    logic [ALU_Len-1:0] op_q;

    logic            start_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   div_shift, div_trial, mul_sum;

    // Operand sign handling and divide special-case detection at accept time
    always_comb begin
        start_div = is_div_op(op);
        a_signed  = (op == ALU_DIV) || (op == ALU_REM) || (op == ALU_MULH) || (op == ALU_MULHSU);
        b_signed  = (op == ALU_DIV) || (op == ALU_REM) || (op == ALU_MULH);
        a_neg     = a_signed & a[XLEN-1];
        b_neg     = b_signed & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div_zero  = start_div && (b == '0);
        div_ovf   = start_div && a_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    // One restoring-divide step and one shift-add multiply step
    always_comb begin
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, dvs_q};
        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    end

    // FSM, step counter and datapath registers
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            state_q <= EX_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            op_q    <= ALU_ADD;
        end else if (flush) begin
            state_q <= EX_IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        count_q <= '0;
                        rem_q   <= '0;
                        if (start_div) begin
                            dvs_q <= b_mag;
                            if (div_zero) begin
                                quo_q   <= XLEN'(DIV_ZERO_QUOT);
                                rem_q   <= a;
                                neg_q   <= 1'b0;
                                rneg_q  <= 1'b0;
                                state_q <= EX_DONE;
                            end else if (div_ovf) begin
                                quo_q   <= a;
                                neg_q   <= 1'b0;
                                rneg_q  <= 1'b0;
                                state_q <= EX_DONE;
                            end else begin
                                quo_q   <= a_mag;
                                neg_q   <= a_neg ^ b_neg;
                                rneg_q  <= a_neg;
                                state_q <= EX_BUSY;
                            end
                        end else begin
                            dvs_q   <= a_mag;
                            quo_q   <= b_mag;
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= 1'b0;
                            state_q <= EX_BUSY;
                        end
                    end
                end
                EX_BUSY: begin
                    if (is_div_op(op_q)) begin
                        if (!div_trial[XLEN]) begin
                            rem_q <= div_trial[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        rem_q <= mul_sum[XLEN:1];
                        quo_q <= {mul_sum[0], quo_q[XLEN-1:1]};
                    end
                    if (count_q == CW'(DIV_STEPS - 1)) begin
                        state_q <= EX_DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                EX_DONE: state_q <= EX_IDLE;
                default: state_q <= EX_IDLE;
            endcase
        end
    end

    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod_raw, prod_fix;

    // Sign correction and result selection, valid only in DONE
    always_comb begin
        quo_fix  = neg_q ? -quo_q : quo_q;
        rem_fix  = rneg_q ? -rem_q : rem_q;
        prod_raw = {rem_q, quo_q};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        result   = '0;
        if (state_q == EX_DONE) begin
            case (op_q)
                ALU_DIV, ALU_DIVU: result = quo_fix;
                ALU_REM, ALU_REMU: result = rem_fix;
                ALU_MUL:           result = prod_fix[XLEN-1:0];
                default:           result = prod_fix[2*XLEN-1:XLEN];
            endcase
        end
    end

    assign busy  = (state_q == EX_BUSY);
    assign done  = (state_q == EX_DONE);
    assign state = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV32I ALU, branch compare and output muxing
// around the iterative mul/div unit. Define MUL_FAST_EN for single-cycle
// multiplies; otherwise multiplies run through the iterative unit.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [XLEN-1:0]       ex_reg1,
    input  logic [XLEN-1:0]       ex_reg2,
    input  logic [XLEN-1:0]       ex_Imm,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_rd_enable,
    input  logic [ALU_Len-1:0]    ex_alu_op,
    input  logic [Branch_Len-1:0] ex_branch_op,
    output logic [XLEN-1:0]       mem_result,
    output logic [XLEN-1:0]       mem_Imm,
    output logic [4:0]            mem_rd,
    output logic                  mem_rd_enable,
    output logic                  branch_taken,
    output logic                  stall_req
);

    logic            md_seq, md_start, md_busy, md_done, is_idle;
    ex_state_t       md_state;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] alu_result;
    logic            alu_valid, br_cond;
    logic [4:0]      shamt;

    assign shamt = ex_reg2[4:0];

`ifdef MUL_FAST_EN
    logic [XLEN:0]            fm_a, fm_b;
    logic signed [2*XLEN+1:0] fm_prod;
    assign fm_a    = {(ex_alu_op != ALU_MULHU) & ex_reg1[XLEN-1], ex_reg1};
    assign fm_b    = {(ex_alu_op == ALU_MULH) & ex_reg2[XLEN-1], ex_reg2};
    assign fm_prod = $signed(fm_a) * $signed(fm_b);
    assign md_seq  = is_div_op(ex_alu_op);
`else
    assign md_seq  = is_div_op(ex_alu_op) | is_mul_op(ex_alu_op);
`endif

    assign is_idle  = (md_state == EX_IDLE);
    assign md_start = md_seq & is_idle & ~flush & (rst != ResetEnable);

    ex_muldiv #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start),
        .op     (ex_alu_op),
        .a      (ex_reg1),
        .b      (ex_reg2),
        .busy   (md_busy),
        .done   (md_done),
        .state  (md_state),
        .result (md_result)
    );

    // Single-cycle ALU; unknown codes flag alu_valid low
    always_comb begin
        alu_result = '0;
        alu_valid  = 1'b1;
        case (ex_alu_op)
            ALU_ADD:  alu_result = ex_reg1 + ex_reg2;
            ALU_SUB:  alu_result = ex_reg1 - ex_reg2;
            ALU_SLL:  alu_result = ex_reg1 << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(ex_reg1) < $signed(ex_reg2))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (ex_reg1 < ex_reg2)};
            ALU_XOR:  alu_result = ex_reg1 ^ ex_reg2;
            ALU_SRL:  alu_result = ex_reg1 >> shamt;
            ALU_SRA:  alu_result = $signed(ex_reg1) >>> shamt;
            ALU_OR:   alu_result = ex_reg1 | ex_reg2;
            ALU_AND:  alu_result = ex_reg1 & ex_reg2;
`ifdef MUL_FAST_EN
            ALU_MUL:  alu_result = fm_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_result = fm_prod[2*XLEN-1:XLEN];
`endif
            default:  alu_valid = 1'b0;
        endcase
    end

    // Branch condition on the raw register operands
    always_comb begin
        case (ex_branch_op)
            BR_BEQ:  br_cond = (ex_reg1 == ex_reg2);
            BR_BNE:  br_cond = (ex_reg1 != ex_reg2);
            BR_BLT:  br_cond = ($signed(ex_reg1) < $signed(ex_reg2));
            BR_BGE:  br_cond = ($signed(ex_reg1) >= $signed(ex_reg2));
            BR_BLTU: br_cond = (ex_reg1 < ex_reg2);
            BR_BGEU: br_cond = (ex_reg1 >= ex_reg2);
            default: br_cond = 1'b0;
        endcase
    end

    // Output muxing: reset and flush squash everything, DONE returns the
    // mul/div result, BUSY and a div accept stall, IDLE returns the ALU
    always_comb begin
        mem_result    = '0;
        mem_Imm       = '0;
        mem_rd        = '0;
        mem_rd_enable = 1'b0;
        branch_taken  = 1'b0;
        stall_req     = 1'b0;
        if (rst != ResetEnable) begin
            mem_Imm = ex_Imm;
            mem_rd  = ex_rd;
            if (flush) begin
                mem_rd_enable = 1'b0;
            end else if (md_done) begin
                mem_result    = md_result;
                mem_rd_enable = ex_rd_enable;
            end else if (md_busy) begin
                stall_req = 1'b1;
            end else if (is_idle) begin
                branch_taken = br_cond;
                if (md_seq) begin
                    stall_req = 1'b1;
                end else begin
                    mem_result    = alu_result;
                    mem_rd_enable = ex_rd_enable & alu_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors for ALU, branch,
// divide/multiply latency and results, special cases and flush.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] ex_reg1, ex_reg2, ex_Imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_enable;
    logic [4:0]  ex_alu_op;
    logic [2:0]  ex_branch_op;
    logic [31:0] mem_result, mem_Imm;
    logic [4:0]  mem_rd;
    logic        mem_rd_enable, branch_taken, stall_req;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef MUL_FAST_EN
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_STALL = 33;
`endif

    ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ex_reg1       (ex_reg1),
        .ex_reg2       (ex_reg2),
        .ex_Imm        (ex_Imm),
        .ex_rd         (ex_rd),
        .ex_rd_enable  (ex_rd_enable),
        .ex_alu_op     (ex_alu_op),
        .ex_branch_op  (ex_branch_op),
        .mem_result    (mem_result),
        .mem_Imm       (mem_Imm),
        .mem_rd        (mem_rd),
        .mem_rd_enable (mem_rd_enable),
        .branch_taken  (branch_taken),
        .stall_req     (stall_req)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a new instruction just after the clock edge, sample 1ns later
    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] br);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        ex_alu_op    = op;
        ex_reg1      = a;
        ex_reg2      = b;
        ex_branch_op = br;
        #1;
    endtask

    // Issue a mul/div, count stall cycles, then check the DONE-cycle result
    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int   n;
        logic bad_en;
        apply(op, a, b, BR_NONE);
        n      = 0;
        bad_en = 1'b0;
        while (stall_req === 1'b1 && n < 100) begin
            if (mem_rd_enable !== 1'b0) bad_en = 1'b1;
            n++;
            @(posedge clk);
            #2;
        end
        check({tag, " stall_cycles"}, n, exp_stall);
        check({tag, " result"}, mem_result, exp_res);
        check({tag, " wen"}, {31'b0, mem_rd_enable}, 32'd1);
        check({tag, " wen_while_stalled"}, {31'b0, bad_en}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        ex_reg1      = 32'h1;
        ex_reg2      = 32'h2;
        ex_Imm       = 32'h1234;
        ex_rd        = 5'd7;
        ex_rd_enable = 1'b1;
        ex_alu_op    = ALU_ADD;
        ex_branch_op = BR_BEQ;
        #2;
        check("rst result", mem_result, 32'h0);
        check("rst imm", mem_Imm, 32'h0);
        check("rst rd", {27'b0, mem_rd}, 32'h0);
        check("rst wen", {31'b0, mem_rd_enable}, 32'h0);
        check("rst stall", {31'b0, stall_req}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU, same cycle
        apply(ALU_ADD, 32'hFFFF_FFFF, 32'h1, BR_NONE);
        check("add wrap", mem_result, 32'h0);
        check("add stall", {31'b0, stall_req}, 32'h0);
        check("add wen", {31'b0, mem_rd_enable}, 32'h1);
        check("add rd", {27'b0, mem_rd}, 32'd7);
        check("add imm", mem_Imm, 32'h1234);
        apply(ALU_SUB, 32'd3, 32'd5, BR_NONE);
        check("sub", mem_result, 32'hFFFF_FFFE);
        apply(ALU_SRA, 32'h8000_0000, 32'h24, BR_NONE);
        check("sra", mem_result, 32'hF800_0000);
        apply(ALU_SRL, 32'h8000_0000, 32'h24, BR_NONE);
        check("srl", mem_result, 32'h0800_0000);
        apply(ALU_SLL, 32'h0000_0003, 32'h1F, BR_NONE);
        check("sll", mem_result, 32'h8000_0000);
        apply(ALU_SLT, 32'hFFFF_FFFF, 32'h1, BR_NONE);
        check("slt", mem_result, 32'h1);
        apply(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, BR_NONE);
        check("sltu", mem_result, 32'h0);

        // Branch compare
        apply(ALU_SUB, 32'hFFFF_FFFF, 32'h1, BR_BLT);
        check("blt", {31'b0, branch_taken}, 32'h1);
        apply(ALU_SUB, 32'hFFFF_FFFF, 32'h1, BR_BLTU);
        check("bltu", {31'b0, branch_taken}, 32'h0);
        apply(ALU_SUB, 32'd5, 32'd5, BR_BEQ);
        check("beq", {31'b0, branch_taken}, 32'h1);
        apply(ALU_SUB, 32'd5, 32'd5, BR_BNE);
        check("bne", {31'b0, branch_taken}, 32'h0);
        apply(ALU_SUB, 32'd5, 32'd5, BR_BGE);
        check("bge", {31'b0, branch_taken}, 32'h1);
        apply(ALU_SUB, 32'd5, 32'd5, BR_NONE);
        check("br none", {31'b0, branch_taken}, 32'h0);

        // Unknown op
        apply(5'd31, 32'd1, 32'd2, BR_NONE);
        check("unknown result", mem_result, 32'h0);
        check("unknown wen", {31'b0, mem_rd_enable}, 32'h0);
        check("unknown stall", {31'b0, stall_req}, 32'h0);

        // Divide, back to back
        run_md("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_md("rem -7%2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_md("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_md("rem 7%-2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'h1, 33);
        run_md("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_md("remu 100%7", ALU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_md("divu /0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_md("remu %0", ALU_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_md("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Multiply
        run_md("mulh min*min", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_STALL);
        run_md("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
        run_md("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALL);
        run_md("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_STALL);

        // Flush in the middle of a divide
        apply(ALU_DIVU, 32'd100, 32'd7, BR_NONE);
        check("flush accept stall", {31'b0, stall_req}, 32'h1);
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        check("flush busy stall", {31'b0, stall_req}, 32'h1);
        flush = 1'b1;
        #1;
        check("flush stall drop", {31'b0, stall_req}, 32'h0);
        check("flush wen", {31'b0, mem_rd_enable}, 32'h0);
        apply(ALU_ADD, 32'd3, 32'd4, BR_NONE);
        check("post flush add", mem_result, 32'd7);
        check("post flush stall", {31'b0, stall_req}, 32'h0);
        check("post flush wen", {31'b0, mem_rd_enable}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline; consumes the ID/EX pipeline register outputs and drives the EX/MEM register inputs.
- Single-cycle ALU for RV32I operations and branch-condition evaluation.
- An iterative radix-2 divider handles DIV/DIVU/REM/REMU; a multiplier handles MUL/MULH/MULHSU/MULHU.
- Raises stall_req to freeze IF/ID/ID-EX while a multi-cycle operation runs.

Parameters:
XLEN, 32, operand/result width
DIV_STEPS, 32, iterations per divide (must equal XLEN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  abort in-flight operation (trap/redirect)
ex_reg1  in  XLEN  operand A
ex_reg2  in  XLEN  operand B (imm already selected by decode for I-type)
ex_Imm  in  XLEN  immediate, forwarded for store/load offset
ex_rd  in  5  destination register index
ex_rd_enable  in  1  writeback enable
ex_alu_op  in  ALU_Len  operation code
ex_branch_op  in  Branch_Len  branch condition code
mem_result  out  XLEN  operation result
mem_Imm  out  XLEN  ex_Imm passthrough
mem_rd  out  5  ex_rd passthrough
mem_rd_enable  out  1  writeback enable, qualified
branch_taken  out  1  branch condition true
stall_req  out  1  hold upstream stages

Behaviour:
- Outputs are combinational from inputs and FSM state. While rst=1, all outputs are 0.
- FSM states are IDLE, BUSY, DONE. Reset and flush force IDLE, clear the counter, and drop stall_req in the same cycle.
- IDLE with an RV32I op:
  - mem_result is the ALU result in the same cycle; stall_req=0.
  - ADD/SUB wrap mod 2^32.
  - Shifts use reg2[4:0]; SRA is arithmetic.
  - SLT is signed; SLTU is unsigned.
- IDLE with a div/rem op:
  - Latch |A|, |B|, and the sign flags.
  - stall_req=1 and mem_rd_enable=0 in this cycle; go to BUSY with count=0.
- Divide special cases skip BUSY and go IDLE→DONE:
  - B=0: quotient 0xFFFFFFFF, remainder = A.
  - Signed A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- BUSY performs one restoring step per cycle (shift remainder/quotient, trial subtract).
  - stall_req=1 and mem_rd_enable=0.
  - At count=DIV_STEPS-1, go to DONE.
- DONE:
  - mem_result is the sign-fixed quotient or remainder. Quotient is negated if signs differ; remainder takes the dividend's sign.
  - stall_req=0, mem_rd_enable=ex_rd_enable. Next state is IDLE.
  - The ID/EX register advances at this edge, so a back-to-back div is accepted in the following IDLE cycle.
- Div latency: accept cycle + 32 BUSY + DONE, i.e. stall_req high for 33 cycles and the result on the 34th.
- branch_taken evaluates ex_branch_op on reg1/reg2 (BEQ, BNE, BLT, BGE, BLTU, BGEU) in IDLE only. It is 0 otherwise and 0 for non-branch codes.
- mem_rd and mem_Imm always pass through.
- An unknown ex_alu_op gives mem_result 0 and mem_rd_enable 0, with no stall.

Optional Feature:
- MUL_FAST_EN defined: MUL* are single-cycle through a combinational 33x33 signed product, with no stall.
- MUL_FAST_EN undefined: MUL* use the same FSM as divide.
  - 32 shift-add steps on magnitudes.
  - The 64-bit product is negated when the operand signs differ, per MULH/MULHSU/MULHU signedness.
  - MUL returns [31:0]; the MULH variants return [63:32].
  - Same 33-cycle stall.

Decomposition:
- Shared defines package holds:
  - ALU_Len, Branch_Len, and all ALU_*/BR_* op encodings.
  - ResetEnable.
  - FSM state encodings (EX_IDLE, EX_BUSY, EX_DONE).
  - DIV-by-zero constants.
- Sub-module ex_muldiv holds the FSM, counter, iterative divider and optional multiplier. It exposes start, op, a, b, flush, busy, done, result.
- ex_stage holds the ALU, the branch compare and the output muxing.

Test Plan:
- ADD reg1=0xFFFFFFFF, reg2=1 → mem_result=0 same cycle, stall_req=0.
- DIV reg1=-7 (0xFFFFFFF9), reg2=2 → stall_req high 33 cycles, then mem_result=0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- DIVU reg2=0 → 1-cycle stall, mem_result=0xFFFFFFFF; REMU with reg1=5 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- flush at BUSY cycle 10 → stall_req=0 next cycle and no write; a following ADD 3+4 → 7 immediately.
- Without MUL_FAST_EN, MULH 0x80000000*0x80000000 → 0x40000000 after 33 stall cycles; with the macro, same result and no stall.
